// File: rtl/convolution_controller.sv
// Streaming 3x3 convolution engine: AXI-Lite register file, AXI-Stream pixel in, AXI-Stream result out.
// States: IDLE (wait for enable) | FILL (accept samples) | CALC1 (register products) | CALC2 (sum) | OUT (present result)
module convolution_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int KERNELSIZE = 3
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  output logic                  ip_reset_out,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_last,
  input  logic [3:0]            s_axis_keep,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  output logic [3:0]            m_axis_keep,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  localparam int TAPS = KERNELSIZE * KERNELSIZE;
  localparam int FW = $clog2(TAPS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_CALC1 = 3'd2;
  localparam logic [2:0] S_CALC2 = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] A_WIDTH  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_HEIGHT = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(12);
  localparam logic [ADDR_WIDTH-1:0] A_COUNT  = ADDR_WIDTH'(16);
  localparam logic [ADDR_WIDTH-1:0] A_COEF   = ADDR_WIDTH'(20);
  localparam logic [ADDR_WIDTH-1:0] A_SOFT   = ADDR_WIDTH'(56);

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] width_q, height_q, count_q, data_q;
  logic [DATA_WIDTH-1:0] row_left_q, grp_left_q;
  logic                  enable_q, done_q, first_q, frame_start_q;
  logic [FW-1:0]         fill_left_q;
  logic [DATA_WIDTH-1:0] win_q  [TAPS];
  logic [DATA_WIDTH-1:0] coef_q [TAPS];
  logic [DATA_WIDTH-1:0] prod_q [TAPS];
  logic                  bvalid_q, rvalid_q, ip_rst_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_val, sum;
  logic [FW-1:0]         tap_idx, grp_col;
  logic                  wr_en, soft_rst, busy, frame_end;
  logic                  unused_ok;

  assign unused_ok = ^{s_axis_last, s_axis_keep};

  assign wr_en     = s_axi_awvalid && s_axi_wvalid;
  assign soft_rst  = wr_en && (s_axi_awaddr == A_SOFT) && s_axi_wdata[0];
  assign busy      = (state_q != S_IDLE);
  assign frame_end = (row_left_q == '0) && (grp_left_q == '0);
  assign tap_idx   = FW'(TAPS - 1) - fill_left_q;
  assign grp_col   = FW'(KERNELSIZE - 1) - fill_left_q;

  assign s_axis_ready  = (state_q == S_FILL);
  assign m_axis_valid  = (state_q == S_OUT);
  assign m_axis_data   = data_q;
  assign m_axis_last   = m_axis_valid && frame_end;
  assign m_axis_keep   = m_axis_valid ? 4'hf : 4'h0;
  assign s_axi_awready = !axi_reset;
  assign s_axi_wready  = !axi_reset;
  assign s_axi_arready = !axi_reset;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign ip_reset_out  = ip_rst_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable_q && width_q >= DATA_WIDTH'(3) && height_q >= DATA_WIDTH'(3)) state_d = S_FILL;
      S_FILL:  if (s_axis_valid && fill_left_q == '0) state_d = S_CALC1;
      S_CALC1: state_d = S_CALC2;
      S_CALC2: state_d = S_OUT;
      S_OUT:   if (m_axis_ready) state_d = frame_end ? S_IDLE : S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < TAPS; j++) sum = sum + prod_q[j];
  end

  always_comb begin
    rd_val = '0;
    case (s_axi_araddr)
      A_WIDTH:  rd_val = width_q;
      A_HEIGHT: rd_val = height_q;
      A_CTRL:   rd_val = DATA_WIDTH'(enable_q);
      A_STATUS: rd_val = DATA_WIDTH'({done_q, busy});
      A_COUNT:  rd_val = count_q;
      default:  ;
    endcase
    for (int j = 0; j < TAPS; j++)
      if (s_axi_araddr == A_COEF + ADDR_WIDTH'(4 * j)) rd_val = coef_q[j];
  end

  // Bus handshakes survive a soft reset so the write that triggered it still gets its response.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ip_rst_q <= 1'b0;
    end else begin
      ip_rst_q <= soft_rst;
      if (wr_en) bvalid_q <= 1'b1;
      else if (s_axi_bready) bvalid_q <= 1'b0;
      if (s_axi_arvalid) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset || soft_rst) begin
      state_q       <= S_IDLE;
      width_q       <= '0;
      height_q      <= '0;
      count_q       <= '0;
      data_q        <= '0;
      row_left_q    <= '0;
      grp_left_q    <= '0;
      enable_q      <= 1'b0;
      done_q        <= 1'b0;
      first_q       <= 1'b0;
      frame_start_q <= 1'b0;
      fill_left_q   <= '0;
      for (int j = 0; j < TAPS; j++) begin
        win_q[j]  <= '0;
        coef_q[j] <= '0;
        prod_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        if (s_axi_awaddr == A_WIDTH && !busy) width_q <= s_axi_wdata;
        if (s_axi_awaddr == A_HEIGHT && !busy) height_q <= s_axi_wdata;
        if (s_axi_awaddr == A_CTRL) enable_q <= s_axi_wdata[0];
        for (int j = 0; j < TAPS; j++)
          if (s_axi_awaddr == A_COEF + ADDR_WIDTH'(4 * j)) coef_q[j] <= s_axi_wdata;
      end
      case (state_q)
        S_IDLE: if (state_d == S_FILL) begin
          row_left_q    <= height_q - DATA_WIDTH'(3);
          grp_left_q    <= width_q - DATA_WIDTH'(3);
          first_q       <= 1'b1;
          frame_start_q <= 1'b1;
          fill_left_q   <= FW'(TAPS - 1);
        end
        S_FILL: if (s_axis_valid) begin
          // The previous frame's count stays readable until this frame's first pixel arrives.
          if (frame_start_q) count_q <= '0;
          frame_start_q <= 1'b0;
          fill_left_q   <= fill_left_q - 1'b1;
          if (first_q) begin
            for (int j = 0; j < TAPS; j++)
              if (tap_idx == FW'(j)) win_q[j] <= s_axis_data;
          end else begin
            for (int j = 0; j < TAPS - KERNELSIZE; j++)
              if (grp_col == FW'(j % KERNELSIZE)) win_q[j] <= win_q[j + KERNELSIZE];
            for (int j = TAPS - KERNELSIZE; j < TAPS; j++)
              if (grp_col == FW'(j % KERNELSIZE)) win_q[j] <= s_axis_data;
          end
        end
        S_CALC1: for (int j = 0; j < TAPS; j++) prod_q[j] <= coef_q[j] * win_q[j];
        S_CALC2: data_q <= sum;
        S_OUT: if (m_axis_ready) begin
          count_q <= count_q + 1'b1;
          if (frame_end) begin
            done_q <= 1'b1;
          end else if (grp_left_q == '0) begin
            row_left_q  <= row_left_q - 1'b1;
            grp_left_q  <= width_q - DATA_WIDTH'(3);
            first_q     <= 1'b1;
            fill_left_q <= FW'(TAPS - 1);
          end else begin
            grp_left_q  <= grp_left_q - 1'b1;
            first_q     <= 1'b0;
            fill_left_q <= FW'(KERNELSIZE - 1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_convolution_controller.sv
// Scoreboard bench for convolution_controller: stimulus pushes expected results, a monitor pops on each handshake.
module tb_convolution_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        ip_reset_out;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [9:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;

  typedef struct packed { logic [31:0] data; logic last; } exp_t;
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] kc[9];
  logic        ip_seen;

  always #5 clk = ~clk;

  convolution_controller dut (
    .axi_clk(clk), .axi_reset(rst), .ip_reset_out(ip_reset_out),
    .s_axis_valid(s_valid), .s_axis_ready(s_ready), .s_axis_data(s_data),
    .s_axis_last(s_last), .s_axis_keep(s_keep),
    .m_axis_valid(m_valid), .m_axis_ready(m_ready), .m_axis_data(m_data),
    .m_axis_last(m_last), .m_axis_keep(m_keep),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0h, expected no result", m_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_data", m_data, e.data);
        check("result_last", 32'(m_last), 32'(e.last));
        check("result_keep", 32'(m_keep), 32'hf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    ip_seen = ip_reset_out;
    check("bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [9:0] a, input logic [31:0] exp);
    araddr = a; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check({name, "_rvalid"}, 32'(rvalid), 32'd1);
    check(name, rdata, exp);
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic send_pixel(input logic [31:0] v);
    int n = 0;
    s_valid = 1'b1; s_data = v;
    while (!s_ready && n < 200) begin tick(); n++; end
    if (!s_ready) begin
      tests++;
      fails++;
      $display("FAIL pixel_accept_timeout: ready low for %0d cycles, expected high", n);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin tick(); n++; end
    check("drain_queue_size", 32'(sb.size()), 32'd0);
  endtask

  task automatic send_row_fixed();
    for (int i = 0; i < 9; i++) send_pixel(32'(i));
    for (int g = 0; g < 2; g++)
      for (int t = 6; t < 9; t++) send_pixel(32'(t));
  endtask

  function automatic logic [31:0] dot(input logic [31:0] w[9]);
    logic [31:0] acc = '0;
    for (int j = 0; j < 9; j++) acc = acc + kc[j] * w[j];
    return acc;
  endfunction

  initial begin
    logic [31:0] win[9];
    logic [31:0] pix[$];
    logic [31:0] px;
    logic        any_ready, any_valid;
    int          n;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_keep = 4'h0; m_ready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; ip_seen = 1'b0;
    repeat (3) tick();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_keep", 32'(m_keep), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_ip_reset_out", 32'(ip_reset_out), 32'd0);
    rst = 1'b0;
    tick();
    check("awready_run", 32'(awready), 32'd1);
    rd_chk("rd_status_reset", 10'd12, 32'd0);

    // Configure 5x5, K[j]=j, enable
    for (int j = 0; j < 9; j++) kc[j] = 32'(j);
    wr(10'd0, 32'd5);
    wr(10'd4, 32'd5);
    for (int j = 0; j < 9; j++) wr(10'(20 + 4 * j), kc[j]);
    wr(10'd8, 32'd1);
    rd_chk("rd_width", 10'd0, 32'd5);
    rd_chk("rd_height", 10'd4, 32'd5);
    rd_chk("rd_k0", 10'd20, 32'd0);
    rd_chk("rd_k8", 10'd52, 32'd8);
    rd_chk("rd_unmapped", 10'd60, 32'd0);

    // Frame A: hand-computed results per row
    m_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      sb.push_back('{data: 32'd204, last: 1'b0});
      sb.push_back('{data: 32'd249, last: 1'b0});
      sb.push_back('{data: 32'd258, last: (r == 2)});
      send_row_fixed();
    end
    drain();
    repeat (2) tick();
    rd_chk("rd_status_done", 10'd12, 32'd3);
    rd_chk("rd_count", 10'd16, 32'd9);

    // Frame B: backpressure, busy-write protection, then soft reset mid-frame
    m_ready = 1'b0;
    sb.push_back('{data: 32'd204, last: 1'b0});
    for (int i = 0; i < 9; i++) send_pixel(32'(i));
    n = 0;
    while (!m_valid && n < 50) begin tick(); n++; end
    check("valid_seen", 32'(m_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      check("stall_data", m_data, 32'd204);
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_s_ready", 32'(s_ready), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    drain();
    wr(10'd0, 32'd7);
    rd_chk("rd_width_busy", 10'd0, 32'd5);
    sb.push_back('{data: 32'd249, last: 1'b0});
    for (int t = 6; t < 9; t++) send_pixel(32'(t));
    drain();
    send_pixel(32'd6);
    send_pixel(32'd7);
    wr(10'd56, 32'd1);
    check("soft_ip_pulse", 32'(ip_seen), 32'd1);
    check("soft_ip_pulse_end", 32'(ip_reset_out), 32'd0);
    rd_chk("rd_width_soft", 10'd0, 32'd0);
    rd_chk("rd_ctrl_soft", 10'd8, 32'd0);
    rd_chk("rd_soft_reg", 10'd56, 32'd0);
    any_ready = 1'b0; any_valid = 1'b0;
    s_valid = 1'b1; s_data = 32'h55;
    for (int c = 0; c < 20; c++) begin
      if (s_ready) any_ready = 1'b1;
      if (m_valid) any_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    check("soft_no_ready", 32'(any_ready), 32'd0);
    check("soft_no_valid", 32'(any_valid), 32'd0);

    // Configured but not enabled
    wr(10'd0, 32'd5);
    wr(10'd4, 32'd5);
    for (int j = 0; j < 9; j++) wr(10'(20 + 4 * j), kc[j]);
    wr(10'd8, 32'd0);
    any_ready = 1'b0;
    s_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (s_ready) any_ready = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    check("disabled_no_ready", 32'(any_ready), 32'd0);

    // Random 16-bit pixels against a software window model
    wr(10'd8, 32'd1);
    for (int j = 0; j < 9; j++) win[j] = '0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 9; i++) begin
        px = 32'($urandom_range(0, 65535));
        win[i] = px;
        pix.push_back(px);
      end
      sb.push_back('{data: dot(win), last: 1'b0});
      for (int g = 0; g < 2; g++) begin
        for (int t = 0; t < 3; t++) begin
          px = 32'($urandom_range(0, 65535));
          win[t] = win[3 + t];
          win[3 + t] = win[6 + t];
          win[6 + t] = px;
          pix.push_back(px);
        end
        sb.push_back('{data: dot(win), last: (r == 2 && g == 1)});
      end
    end
    foreach (pix[i]) send_pixel(pix[i]);
    drain();

    // Minimum 3x3 frame, all coefficients -1: single wrapped result, flagged last
    wr(10'd56, 32'd1);
    check("soft2_ip_pulse", 32'(ip_seen), 32'd1);
    wr(10'd0, 32'd3);
    wr(10'd4, 32'd3);
    for (int j = 0; j < 9; j++) wr(10'(20 + 4 * j), 32'hffff_ffff);
    wr(10'd8, 32'd1);
    sb.push_back('{data: 32'hffff_ffd3, last: 1'b1});
    for (int i = 1; i <= 9; i++) send_pixel(32'(i));
    drain();
    repeat (2) tick();
    rd_chk("rd_count_3x3", 10'd16, 32'd1);
    rd_chk("rd_status_3x3", 10'd12, 32'd3);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
